// File: rtl/mux_n_pipe_pkg.sv
// +--------------------------------------------------------------------+
// | mux_n_pipe_pkg : shared width constants and select-width helper    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package mux_n_pipe_pkg;

  localparam int XLEN = 32;

  // A single-bit select is the minimum, even for two inputs.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_n_comb.sv
// +--------------------------------------------------------------------+
// | mux_n_comb : N-input select mux, zero output on illegal select     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module mux_n_comb
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int N_IN  = 3,
  parameter int SEL_W = sel_width(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  illegal
);

  always_comb begin
    out_data = '0;
    illegal  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
        illegal  = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_n_pipe.sv
// +--------------------------------------------------------------------+
// | mux_n_pipe : registered N-input mux with skid buffer, flush and    |
// |              sticky illegal-select flag. Revision 1.0               |
// +--------------------------------------------------------------------+
`default_nettype none

module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter  int WIDTH = XLEN,
  parameter  int N_IN  = 3,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  err_sel,
  input  logic                  err_clr
);

  logic [WIDTH-1:0] w_sel_data;
  logic             w_illegal;
  logic             w_accept;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_valid;
  logic             r_err_sel;

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_data  (in_data),
    .sel      (in_sel),
    .out_data (w_sel_data),
    .illegal  (w_illegal)
  );

  // in_ready comes straight from the skid flag, so out_ready never reaches it.
  assign in_ready = !r_skid_valid;
  assign w_accept = in_valid && !r_skid_valid && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_err_sel    <= 1'b0;
    end else begin
      if (flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (r_skid_valid) begin
        if (out_ready) begin
          r_out_data   <= r_skid_data;
          r_skid_valid <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_out_valid || out_ready) begin
          r_out_data  <= w_sel_data;
          r_out_valid <= 1'b1;
        end else begin
          r_skid_data  <= w_sel_data;
          r_skid_valid <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A new illegal select takes priority over a same-edge clear.
      if (w_accept && w_illegal) begin
        r_err_sel <= 1'b1;
      end else if (err_clr) begin
        r_err_sel <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign err_sel   = r_err_sel;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
// +--------------------------------------------------------------------+
// | tb_mux_n_pipe : directed (N_IN=3) and random (N_IN=5) scoreboard   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mux_n_pipe;

  localparam int W_A = 32;
  localparam int N_A = 3;
  localparam int W_B = 8;
  localparam int N_B = 5;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  // Instance A: default width, three inputs
  logic [W_A-1:0]     a_ins [N_A];
  logic [N_A*W_A-1:0] a_in_data;
  logic [1:0]         a_in_sel;
  logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic               a_flush, a_err_sel, a_err_clr;
  logic [W_A-1:0]     a_out_data;

  // Instance B: byte width, five inputs
  logic [W_B-1:0]     b_ins [N_B];
  logic [N_B*W_B-1:0] b_in_data;
  logic [2:0]         b_in_sel;
  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic               b_flush, b_err_sel, b_err_clr;
  logic [W_B-1:0]     b_out_data;

  always_comb begin
    a_in_data = '0;
    for (int k = 0; k < N_A; k++) a_in_data[k*W_A +: W_A] = a_ins[k];
  end
  always_comb begin
    b_in_data = '0;
    for (int k = 0; k < N_B; k++) b_in_data[k*W_B +: W_B] = b_ins[k];
  end

  mux_n_pipe #(.WIDTH(W_A), .N_IN(N_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .flush(a_flush),
    .err_sel(a_err_sel), .err_clr(a_err_clr)
  );

  mux_n_pipe #(.WIDTH(W_B), .N_IN(N_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .flush(b_flush),
    .err_sel(b_err_sel), .err_clr(b_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each block is a FIFO of at most two words; the front is what
  // the output shows. Words are the selected input or zero for bad selects.
  function automatic logic [31:0] a_expect();
    return (a_in_sel < N_A) ? a_ins[a_in_sel] : 32'h0;
  endfunction
  function automatic logic [31:0] b_expect();
    return (b_in_sel < N_B) ? 32'(b_ins[b_in_sel]) : 32'h0;
  endfunction

  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  logic        a_err, b_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q.delete();
      a_err <= 1'b0;
    end else begin
      if (a_in_valid && !a_flush && a_q.size() < 2 && a_in_sel >= N_A) a_err <= 1'b1;
      else if (a_err_clr) a_err <= 1'b0;
      if (a_flush) a_q.delete();
      else if (a_q.size() == 0) begin
        if (a_in_valid) a_q.push_back(a_expect());
      end else if (a_q.size() == 1) begin
        if (a_in_valid) a_q.push_back(a_expect());
        if (a_out_ready) void'(a_q.pop_front());
      end else if (a_out_ready) void'(a_q.pop_front());
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q.delete();
      b_err <= 1'b0;
    end else begin
      if (b_in_valid && !b_flush && b_q.size() < 2 && b_in_sel >= N_B) b_err <= 1'b1;
      else if (b_err_clr) b_err <= 1'b0;
      if (b_flush) b_q.delete();
      else if (b_q.size() == 0) begin
        if (b_in_valid) b_q.push_back(b_expect());
      end else if (b_q.size() == 1) begin
        if (b_in_valid) b_q.push_back(b_expect());
        if (b_out_ready) void'(b_q.pop_front());
      end else if (b_out_ready) void'(b_q.pop_front());
    end
  end

  // Monitors: compare the presented output against the scoreboard front
  always @(negedge clk) begin
    chk("a_in_ready", 32'(a_in_ready), 32'(a_q.size() < 2));
    chk("a_out_valid", 32'(a_out_valid), 32'(a_q.size() > 0));
    if (a_q.size() > 0) chk("a_out_data", a_out_data, a_q[0]);
    chk("a_err_sel", 32'(a_err_sel), 32'(a_err));
  end

  always @(negedge clk) begin
    chk("b_in_ready", 32'(b_in_ready), 32'(b_q.size() < 2));
    chk("b_out_valid", 32'(b_out_valid), 32'(b_q.size() > 0));
    if (b_q.size() > 0) chk("b_out_data", 32'(b_out_data), b_q[0]);
    chk("b_err_sel", 32'(b_err_sel), 32'(b_err));
  end

  task automatic drive_a(input bit v, input int s, input bit r, input bit f, input bit c);
    @(negedge clk);
    #1;
    a_in_valid  = v;
    a_in_sel    = s[1:0];
    a_out_ready = r;
    a_flush     = f;
    a_err_clr   = c;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_in_sel = 0; a_out_ready = 0; a_flush = 0; a_err_clr = 0;
    b_in_valid = 0; b_in_sel = 0; b_out_ready = 0; b_flush = 0; b_err_clr = 0;
    a_ins[0] = 32'h11111111; a_ins[1] = 32'h22222222; a_ins[2] = 32'h33333333;
    for (int k = 0; k < N_B; k++) b_ins[k] = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Basic select, one word per cycle
    drive_a(1, 0, 1, 0, 0); after_edge(); chk("basic0", a_out_data, 32'h11111111);
    drive_a(1, 1, 1, 0, 0); after_edge(); chk("basic1", a_out_data, 32'h22222222);
    drive_a(1, 2, 1, 0, 0); after_edge(); chk("basic2", a_out_data, 32'h33333333);
    chk("basic_valid", 32'(a_out_valid), 32'h1);

    // Illegal select, sticky flag, clear, then set-beats-clear
    drive_a(1, 3, 1, 0, 0); after_edge();
    chk("illegal_data", a_out_data, 32'h0);
    chk("illegal_err", 32'(a_err_sel), 32'h1);
    drive_a(0, 0, 1, 0, 0);
    repeat (10) @(negedge clk);
    chk("err_sticky", 32'(a_err_sel), 32'h1);
    drive_a(0, 0, 1, 0, 1); after_edge(); chk("err_clr", 32'(a_err_sel), 32'h0);
    drive_a(1, 3, 1, 0, 1); after_edge(); chk("err_set_wins", 32'(a_err_sel), 32'h1);
    drive_a(0, 0, 1, 0, 1); drive_a(0, 0, 1, 0, 0);

    // Back-pressure: A to output, B to skid, C stalls, then drain in order
    drive_a(1, 0, 0, 0, 0);
    drive_a(1, 1, 0, 0, 0);
    drive_a(1, 2, 0, 0, 0); after_edge();
    chk("bp_ready", 32'(a_in_ready), 32'h0);
    chk("bp_hold", a_out_data, 32'h11111111);
    drive_a(1, 2, 0, 0, 0);
    drive_a(1, 2, 1, 0, 0); after_edge(); chk("bp_b", a_out_data, 32'h22222222);
    drive_a(1, 2, 1, 0, 0); after_edge(); chk("bp_c", a_out_data, 32'h33333333);
    drive_a(0, 0, 1, 0, 0); drive_a(0, 0, 0, 0, 0);

    // Flush with both entries full and a word on offer
    drive_a(1, 0, 0, 0, 0);
    drive_a(1, 1, 0, 0, 0);
    drive_a(1, 2, 0, 1, 0); after_edge();
    chk("flush_valid", 32'(a_out_valid), 32'h0);
    chk("flush_ready", 32'(a_in_ready), 32'h1);
    drive_a(1, 2, 1, 0, 0); after_edge();
    chk("post_flush", a_out_data, 32'h33333333);
    drive_a(0, 0, 1, 0, 0);

    // Asynchronous reset with output and skid full and the flag set
    drive_a(1, 3, 0, 0, 0);
    drive_a(1, 1, 0, 0, 0);
    drive_a(0, 0, 0, 0, 0); after_edge();
    chk("pre_rst_ready", 32'(a_in_ready), 32'h0);
    chk("pre_rst_err", 32'(a_err_sel), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'h0);
    chk("rst_in_ready", 32'(a_in_ready), 32'h1);
    chk("rst_err_sel", 32'(a_err_sel), 32'h0);
    chk("rst_out_data", a_out_data, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Random traffic on the five-input instance
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < N_B; k++) b_ins[k] = 8'($urandom);
      b_in_sel    = 3'($urandom_range(0, 7));
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush     = ($urandom_range(0, 19) == 0);
      b_err_clr   = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    #1;
    b_in_valid = 0; b_flush = 0; b_err_clr = 0; b_out_ready = 1;
    repeat (4) @(negedge clk);
    chk("b_drained", 32'(b_out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
